// File: rtl/range_seq_ctrl.sv
// Frame sequencer that owns a rangefinder: turns a valid/ready sample stream into legal go/finish frames
// and returns the captured range with status. Define RANGE_SEQ_TIMEOUT_EN to enable the RUN idle-gap watchdog.
module range_seq_ctrl #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned MAX_LEN = 255,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] res_range,
    output logic [7:0]       res_count,
    output logic             res_error,
    output logic             res_trunc,
    output logic             res_timeout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             rf_go,
    output logic             rf_finish,
    output logic [WIDTH-1:0] rf_data,
    input  logic [WIDTH-1:0] rf_range,
    input  logic             rf_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FIN,
        S_CAPT,
        S_DONE
    } state_t;

`ifdef RANGE_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic             rf_go_q, rf_go_d;
    logic             rf_finish_q, rf_finish_d;
    logic [WIDTH-1:0] rf_data_q, rf_data_d;
    logic [7:0]       count_q, count_d;
    logic             pend_q, pend_d;
    logic             trunc_q, trunc_d;
    logic             err_q, err_d;
    logic             tmo_q, tmo_d;
    logic [TW-1:0]    idle_q, idle_d;
    logic [WIDTH-1:0] res_range_q, res_range_d;
    logic [7:0]       res_count_q, res_count_d;
    logic             res_error_q, res_error_d;
    logic             res_trunc_q, res_trunc_d;
    logic             res_timeout_q, res_timeout_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rf_go_q       <= 1'b0;
            rf_finish_q   <= 1'b0;
            rf_data_q     <= '0;
            count_q       <= '0;
            pend_q        <= 1'b0;
            trunc_q       <= 1'b0;
            err_q         <= 1'b0;
            tmo_q         <= 1'b0;
            idle_q        <= '0;
            res_range_q   <= '0;
            res_count_q   <= '0;
            res_error_q   <= 1'b0;
            res_trunc_q   <= 1'b0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rf_go_q       <= rf_go_d;
            rf_finish_q   <= rf_finish_d;
            rf_data_q     <= rf_data_d;
            count_q       <= count_d;
            pend_q        <= pend_d;
            trunc_q       <= trunc_d;
            err_q         <= err_d;
            tmo_q         <= tmo_d;
            idle_q        <= idle_d;
            res_range_q   <= res_range_d;
            res_count_q   <= res_count_d;
            res_error_q   <= res_error_d;
            res_trunc_q   <= res_trunc_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rf_go_d       = 1'b0;
        rf_finish_d   = 1'b0;
        rf_data_d     = rf_data_q;
        count_d       = count_q;
        pend_d        = pend_q;
        trunc_d       = trunc_q;
        err_d         = err_q;
        tmo_d         = tmo_q;
        idle_d        = idle_q;
        res_range_d   = res_range_q;
        res_count_d   = res_count_q;
        res_error_d   = res_error_q;
        res_trunc_d   = res_trunc_q;
        res_timeout_d = res_timeout_q;
        in_ready      = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    rf_data_d = in_data;
                    rf_go_d   = 1'b1;
                    count_d   = 8'd1;
                    err_d     = 1'b0;
                    tmo_d     = 1'b0;
                    idle_d    = '0;
                    // A frame that already ends here cannot finish alongside go; RUN finishes it next.
                    pend_d    = in_last || (MAX_LEN == 1);
                    trunc_d   = !in_last && (MAX_LEN == 1);
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                err_d = err_q | rf_error;
                if (pend_q) begin
                    rf_finish_d = 1'b1;
                    state_d     = S_FIN;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        rf_data_d = in_data;
                        count_d   = count_q + 8'd1;
                        idle_d    = '0;
                        if (in_last || (count_q == 8'(MAX_LEN - 1))) begin
                            trunc_d     = !in_last;
                            rf_finish_d = 1'b1;
                            state_d     = S_FIN;
                        end
                    end else if (TMO_EN && (idle_q == TW'(TIMEOUT - 1))) begin
                        tmo_d       = 1'b1;
                        rf_finish_d = 1'b1;
                        state_d     = S_FIN;
                    end else begin
                        idle_d = idle_q + TW'(1);
                    end
                end
            end
            S_FIN: begin
                err_d   = err_q | rf_error;
                state_d = S_CAPT;
            end
            S_CAPT: begin
                res_range_d   = rf_range;
                res_count_d   = count_q;
                res_error_d   = err_q | rf_error;
                res_trunc_d   = trunc_q;
                res_timeout_d = tmo_q;
                state_d       = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rf_go       = rf_go_q;
    assign rf_finish   = rf_finish_q;
    assign rf_data     = rf_data_q;
    assign res_range   = res_range_q;
    assign res_count   = res_count_q;
    assign res_error   = res_error_q;
    assign res_trunc   = res_trunc_q;
    assign res_timeout = res_timeout_q;
    assign res_valid   = (state_q == S_DONE);

endmodule

// File: tb/tb_range_seq_ctrl.sv
// Directed bench for range_seq_ctrl: instance 0 uses defaults, instance 1 uses MAX_LEN=4, TIMEOUT=8.
// Each instance drives a behavioural rangefinder (range = max - min over the go..finish window).
module tb_range_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_data   [2];
    logic        in_valid  [2];
    logic        in_last   [2];
    logic        in_ready  [2];
    logic [15:0] res_range [2];
    logic [7:0]  res_count [2];
    logic        res_error [2];
    logic        res_trunc [2];
    logic        res_timeout [2];
    logic        res_valid [2];
    logic        res_ready [2];
    logic        rf_go     [2];
    logic        rf_finish [2];
    logic [15:0] rf_data   [2];
    logic        rf_err    [2];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [15:0] rng = '0;
        logic [15:0] mn = '0;
        logic [15:0] mx = '0;
        logic        act = 1'b0;
        int          go_cnt = 0;
        int          fin_cnt = 0;
        int          overlap = 0;

        range_seq_ctrl #(
            .WIDTH  (16),
            .MAX_LEN(g == 0 ? 255 : 4),
            .TIMEOUT(g == 0 ? 64 : 8)
        ) dut (
            .clock      (clock),
            .reset      (reset),
            .in_data    (in_data[g]),
            .in_valid   (in_valid[g]),
            .in_last    (in_last[g]),
            .in_ready   (in_ready[g]),
            .res_range  (res_range[g]),
            .res_count  (res_count[g]),
            .res_error  (res_error[g]),
            .res_trunc  (res_trunc[g]),
            .res_timeout(res_timeout[g]),
            .res_valid  (res_valid[g]),
            .res_ready  (res_ready[g]),
            .rf_go      (rf_go[g]),
            .rf_finish  (rf_finish[g]),
            .rf_data    (rf_data[g]),
            .rf_range   (rng),
            .rf_error   (rf_err[g])
        );

        always @(posedge clock) begin
            if (reset) begin
                act <= 1'b0;
                mn  <= '0;
                mx  <= '0;
                rng <= '0;
            end else if (rf_go[g]) begin
                act <= 1'b1;
                mn  <= rf_data[g];
                mx  <= rf_data[g];
            end else if (act) begin
                if (rf_finish[g]) begin
                    rng <= ((rf_data[g] > mx) ? rf_data[g] : mx) - ((rf_data[g] < mn) ? rf_data[g] : mn);
                    act <= 1'b0;
                end else begin
                    if (rf_data[g] < mn) mn <= rf_data[g];
                    if (rf_data[g] > mx) mx <= rf_data[g];
                end
            end
        end

        always @(posedge clock) begin
            if (rf_go[g]) go_cnt <= go_cnt + 1;
            if (rf_finish[g]) fin_cnt <= fin_cnt + 1;
            if (rf_go[g] && rf_finish[g]) overlap <= overlap + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle(input int u);
        in_valid[u] = 1'b0;
        in_last[u]  = 1'b0;
    endtask

    task automatic send(input int u, input logic [15:0] d, input logic last, output int hs);
        bit done = 1'b0;
        hs = -1;
        in_data[u]  = d;
        in_valid[u] = 1'b1;
        in_last[u]  = last;
        for (int n = 0; n < 200 && !done; n++) begin
            if (in_ready[u]) begin
                hs   = cyc;
                done = 1'b1;
            end
            @(negedge clock);
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $error("FAIL send_wait u=%0d: observed no in_ready, expected within 200 cycles", u);
        end
    endtask

    task automatic wait_valid(input int u, output int at);
        bit seen = 1'b0;
        at = -1;
        for (int n = 0; n < 50 && !seen; n++) begin
            if (res_valid[u]) begin
                at   = cyc;
                seen = 1'b1;
            end else begin
                @(negedge clock);
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $error("FAIL res_valid_wait u=%0d: observed no res_valid, expected within 50 cycles", u);
        end
    endtask

    task automatic check_result(input int u, input logic [15:0] rng, input logic [7:0] cnt,
                                input logic err, input logic trn, input logic tmo);
        check("res_valid", res_valid[u], 1'b1);
        check("res_range", res_range[u], rng);
        check("res_count", res_count[u], cnt);
        check("res_error", res_error[u], err);
        check("res_trunc", res_trunc[u], trn);
        check("res_timeout", res_timeout[u], tmo);
    endtask

    initial begin
        int h, h2, t, gc, fc;
        for (int u = 0; u < 2; u++) begin
            in_data[u]   = '0;
            in_valid[u]  = 1'b0;
            in_last[u]   = 1'b0;
            res_ready[u] = 1'b1;
            rf_err[u]    = 1'b0;
        end

        // Reset held two cycles, then first free cycle.
        repeat (2) tick();
        reset = 1'b0;
        for (int u = 0; u < 2; u++) begin
            check("rst_in_ready", in_ready[u], 1'b1);
            check("rst_rf_go", rf_go[u], 1'b0);
            check("rst_rf_finish", rf_finish[u], 1'b0);
            check("rst_rf_data", rf_data[u], 16'h0);
            check("rst_res_valid", res_valid[u], 1'b0);
            check("rst_res_range", res_range[u], 16'h0);
            check("rst_res_count", res_count[u], 8'h0);
            check("rst_res_flags", {res_error[u], res_trunc[u], res_timeout[u]}, 3'b000);
        end

        // Back-to-back 0x10, 0x35, 0x22(last).
        gc = g_dut[0].go_cnt;
        send(0, 16'h10, 1'b0, h);
        check("b2b_go", rf_go[0], 1'b1);
        check("b2b_go_data", rf_data[0], 16'h10);
        send(0, 16'h35, 1'b0, h);
        check("b2b_go_low", rf_go[0], 1'b0);
        check("b2b_data2", rf_data[0], 16'h35);
        send(0, 16'h22, 1'b1, h);
        idle(0);
        check("b2b_finish", rf_finish[0], 1'b1);
        check("b2b_fin_data", rf_data[0], 16'h22);
        check("b2b_fin_ready", in_ready[0], 1'b0);
        wait_valid(0, t);
        check("b2b_latency", t - h, 3);
        check_result(0, 16'h25, 8'd3, 1'b0, 1'b0, 1'b0);
        check("b2b_go_pulses", g_dut[0].go_cnt - gc, 1);
        tick();
        check("b2b_back_idle", in_ready[0], 1'b1);
        check("b2b_valid_drop", res_valid[0], 1'b0);

        // Same frame with 5-cycle gaps.
        send(0, 16'h10, 1'b0, h);
        idle(0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("gap_hold_10", rf_data[0], 16'h10);
        end
        send(0, 16'h35, 1'b0, h);
        idle(0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("gap_hold_35", rf_data[0], 16'h35);
        end
        send(0, 16'h22, 1'b1, h);
        idle(0);
        wait_valid(0, t);
        check_result(0, 16'h25, 8'd3, 1'b0, 1'b0, 1'b0);
        tick();

        // rf_error pulse inside a frame.
        send(0, 16'h01, 1'b0, h);
        rf_err[0] = 1'b1;
        idle(0);
        tick();
        rf_err[0] = 1'b0;
        send(0, 16'h03, 1'b1, h);
        idle(0);
        wait_valid(0, t);
        check_result(0, 16'h02, 8'd2, 1'b1, 1'b0, 1'b0);
        tick();

        // Single-sample frame.
        send(0, 16'h7F, 1'b1, h);
        idle(0);
        check("single_go", rf_go[0], 1'b1);
        check("single_go_nofin", rf_finish[0], 1'b0);
        check("single_pend_ready", in_ready[0], 1'b0);
        check("single_go_data", rf_data[0], 16'h7F);
        tick();
        check("single_go_fall", rf_go[0], 1'b0);
        check("single_finish", rf_finish[0], 1'b1);
        check("single_fin_data", rf_data[0], 16'h7F);
        wait_valid(0, t);
        check("single_latency", t - h, 4);
        check_result(0, 16'h0, 8'd1, 1'b0, 1'b0, 1'b0);
        tick();

        // Reset mid-RUN.
        send(0, 16'h44, 1'b0, h);
        send(0, 16'h45, 1'b0, h);
        idle(0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_go", rf_go[0], 1'b0);
        check("midrst_finish", rf_finish[0], 1'b0);
        check("midrst_data", rf_data[0], 16'h0);
        check("midrst_ready", in_ready[0], 1'b1);
        check("midrst_count", res_count[0], 8'h0);
        send(0, 16'h60, 1'b0, h);
        send(0, 16'h61, 1'b1, h);
        idle(0);
        wait_valid(0, t);
        check_result(0, 16'h01, 8'd2, 1'b0, 1'b0, 1'b0);
        tick();

        // MAX_LEN=4: six samples, last on the sixth, result held back for 10 cycles.
        res_ready[1] = 1'b0;
        send(1, 16'h05, 1'b0, h);
        send(1, 16'h40, 1'b0, h);
        send(1, 16'h20, 1'b0, h);
        send(1, 16'h11, 1'b0, h);
        check("cut_finish", rf_finish[1], 1'b1);
        check("cut_ready", in_ready[1], 1'b0);
        in_data[1] = 16'h30;
        wait_valid(1, t);
        check("cut_latency", t - h, 3);
        check_result(1, 16'h3B, 8'd4, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", res_valid[1], 1'b1);
            check("hold_ready", in_ready[1], 1'b0);
            check("hold_range", res_range[1], 16'h3B);
            check("hold_count", res_count[1], 8'd4);
            check("hold_trunc", res_trunc[1], 1'b1);
        end
        res_ready[1] = 1'b1;
        send(1, 16'h30, 1'b0, h);
        check("after_cut_go", rf_go[1], 1'b1);
        check("after_cut_data", rf_data[1], 16'h30);
        send(1, 16'h08, 1'b1, h);
        idle(1);
        wait_valid(1, t);
        check_result(1, 16'h28, 8'd2, 1'b0, 1'b0, 1'b0);
        tick();

        // in_last on the MAX_LEN-th sample: no truncation.
        send(1, 16'h01, 1'b0, h);
        send(1, 16'h02, 1'b0, h);
        send(1, 16'h03, 1'b0, h);
        send(1, 16'h09, 1'b1, h);
        idle(1);
        wait_valid(1, t);
        check_result(1, 16'h08, 8'd4, 1'b0, 1'b0, 1'b0);
        tick();

`ifdef RANGE_SEQ_TIMEOUT_EN
        // Watchdog closes the frame after 8 idle cycles.
        send(1, 16'h10, 1'b0, h);
        send(1, 16'h18, 1'b0, h);
        idle(1);
        t = -1;
        for (int n = 0; n < 40 && t < 0; n++) begin
            if (rf_finish[1]) t = cyc;
            else tick();
        end
        check("tmo_finish_delay", t - h, 9);
        check("tmo_fin_data", rf_data[1], 16'h18);
        wait_valid(1, t);
        check_result(1, 16'h08, 8'd2, 1'b0, 1'b0, 1'b1);
        tick();

        // Sample on the expiry cycle wins.
        send(1, 16'h10, 1'b0, h);
        send(1, 16'h18, 1'b0, h);
        idle(1);
        repeat (7) tick();
        send(1, 16'h50, 1'b1, h2);
        idle(1);
        check("exp_accept_cycle", h2 - h, 8);
        check("exp_finish", rf_finish[1], 1'b1);
        wait_valid(1, t);
        check_result(1, 16'h40, 8'd3, 1'b0, 1'b0, 1'b0);
        tick();
`else
        // No watchdog: a long gap in RUN never closes the frame.
        fc = g_dut[1].fin_cnt;
        send(1, 16'h05, 1'b0, h);
        idle(1);
        repeat (80) tick();
        check("nowd_finish_count", g_dut[1].fin_cnt - fc, 0);
        check("nowd_ready", in_ready[1], 1'b1);
        send(1, 16'h09, 1'b1, h);
        idle(1);
        wait_valid(1, t);
        check_result(1, 16'h04, 8'd2, 1'b0, 1'b0, 1'b0);
        tick();
`endif

        check("overlap_u0", g_dut[0].overlap, 0);
        check("overlap_u1", g_dut[1].overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
